// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locked sharing of one FIFO write port
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NUM_REQ-1:0]                  i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       i_req_data,
  output logic [NUM_REQ-1:0]                  o_req_ready,
  output logic [DATA_WIDTH-1:0]               o_fifo_wdata,
  output logic                                o_fifo_winc,
  input  logic                                i_fifo_wfull,
  output logic [NUM_REQ-1:0]                  o_grant,
  output logic [$clog2(MAX_BURST+1)-1:0]      o_beat_cnt
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST+1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  logic [0:0]    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, gnt_idx_q, gnt_idx_d, sel, cand;
  logic [CW-1:0] beat_q, beat_d;
  logic          any_valid, active, valid_g, xfer, last_beat, rel;
  // Round-robin pick: walk downwards so the lowest offset from rr_ptr wins
  always_comb begin
    sel = rr_ptr_q;
    cand = '0;
    any_valid = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      cand = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (i_req_valid[cand]) begin
        sel = cand;
        any_valid = 1'b1;
      end
    end
  end
  // Datapath and handshake; everything is gated off while reset is high
  always_comb begin
    active       = (state_q == GRANT) && !i_rst;
    valid_g      = i_req_valid[gnt_idx_q];
    xfer         = active && valid_g && !i_fifo_wfull;
    last_beat    = beat_q == CW'(MAX_BURST-1);
    rel          = active && (!valid_g || (xfer && last_beat));
    o_req_ready  = (active && !i_fifo_wfull) ? ONE << gnt_idx_q : '0;
    o_fifo_winc  = xfer;
    o_fifo_wdata = active ? i_req_data[gnt_idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    o_grant      = (state_q == GRANT) ? ONE << gnt_idx_q : '0;
    o_beat_cnt   = beat_q;
  end
  // Next-state: grant from IDLE, count beats, release to IDLE and advance pointer
  always_comb begin
    state_d   = (state_q == IDLE) ? (any_valid ? GRANT : IDLE) : (rel ? IDLE : GRANT);
    gnt_idx_d = (state_q == IDLE && any_valid) ? sel : gnt_idx_q;
    beat_d    = (state_q == IDLE) ? (any_valid ? '0 : beat_q) : beat_q + CW'(xfer);
    rr_ptr_d  = rel ? ((gnt_idx_q == IW'(NUM_REQ-1)) ? '0 : gnt_idx_q + 1'b1) : rr_ptr_q;
  end
  // State registers; reset overrides any release in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      beat_q    <= beat_d;
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single FIFO write port (wdata/winc, observing wfull) among NUM_REQ requesters.
- Uses round-robin arbitration with burst locking: a grant is held for up to MAX_BURST accepted beats, or until the granted requester drops valid.
- Sits in the write-clock domain in front of the async FIFO. Port naming follows the codebase i_/o_ convention.

Parameters:
- DATA_WIDTH, 8, width of each requester's data and of the FIFO write data.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum beats accepted per grant (>=1).

Ports:
- i_clk  input  1  single clock (FIFO write clock).
- i_rst  input  1  synchronous reset, active-high.
- i_req_valid  input  NUM_REQ  per-requester data valid.
- i_req_data  input  NUM_REQ*DATA_WIDTH  packed requester data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_req_ready  output  NUM_REQ  per-requester accept.
- o_fifo_wdata  output  DATA_WIDTH  FIFO write data.
- o_fifo_winc  output  1  FIFO write strobe.
- i_fifo_wfull  input  1  FIFO full flag.
- o_grant  output  NUM_REQ  one-hot current grant; all-zero when idle.
- o_beat_cnt  output  $clog2(MAX_BURST+1)  beats accepted in the current grant.

Behaviour:
- Reset: i_rst is sampled on the i_clk rising edge. After the edge, state=IDLE, rr_ptr=0, o_grant=0, o_beat_cnt=0.
- Reset gating: o_req_ready, o_fifo_winc and o_fifo_wdata are combinationally forced to 0 while i_rst=1. No FIFO write occurs in any reset cycle, including a reset asserted mid-burst.
- FSM IDLE:
  - o_grant=0, o_req_ready=0, o_fifo_winc=0, o_fifo_wdata=0.
  - If any i_req_valid bit is set, select the first set bit searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Register it into o_grant, clear o_beat_cnt, go to GRANT.
  - Arbitration latency: 1 cycle from valid to grant.
- FSM GRANT (granted index g):
  - o_req_ready[g] = ~i_fifo_wfull. All other ready bits are 0.
  - Transfer = i_req_valid[g] & o_req_ready[g].
  - o_fifo_winc = transfer. o_fifo_wdata = requester g's data, combinational in the same cycle.
  - On transfer, o_beat_cnt increments.
- Release conditions (next state IDLE, rr_ptr <= (g+1) mod NUM_REQ, o_grant cleared):
  - a transfer that brings o_beat_cnt to MAX_BURST; or
  - i_req_valid[g]=0 in any GRANT cycle, whether or not full is asserted.
- Release costs one IDLE bubble cycle before the next grant.
- Full handling: while i_fifo_wfull=1 in GRANT, there is no transfer, o_beat_cnt holds and the grant holds indefinitely. There is no timeout.
- Requester rule: once valid is asserted, data holds stable until ready. Dropping valid ends that requester's burst.
- Simultaneous release and reset: reset wins; rr_ptr becomes 0.
- Requesters not granted never see ready=1.
- o_grant is always one-hot or zero.
- o_beat_cnt never exceeds MAX_BURST.

Test Plan:
- Reset: hold i_rst=1 for 3 cycles with all i_req_valid=1 and wfull=0 -> o_fifo_winc=0 and o_req_ready=0 in every reset cycle; after reset, o_grant=0001 one cycle after the first sampled idle edge.
- Single requester (defaults): req1 supplies 6 beats 0x10..0x15 with wfull=0 -> grant 0010 one cycle later; 4 winc beats 0x10..0x13; one bubble; regrant to req1; 2 beats 0x14..0x15. Exactly 6 winc pulses, in order.
- Fairness: all 4 requesters continuously valid -> grant sequence 0,1,2,3,0; 4 beats each; 1 bubble between grants; o_beat_cnt peaks at 4.
- Full stall: wfull=1 after beat 2 of req0 for 5 cycles -> ready=0, winc=0, grant=0001 and o_beat_cnt=2 held throughout; beats 3 and 4 complete once wfull=0, then release.
- Early release: req2 drops valid after 1 beat while req0 and req3 are valid -> release with o_beat_cnt=1; next grant is req3 (rr_ptr=3), then req0.
- Mid-burst reset: i_rst=1 for 1 cycle during beat 2 of req1 -> no winc in that cycle; state IDLE, rr_ptr=0; next grant is to req0 if it is valid.
